// File: rtl/control_unit.sv
// control_unit: hardwired Moore sequencer for the single-bus datapath.
// Optional MUL_DIV_EN macro enables the mul/div sequences (else 14/15 are nop).
module control_unit (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        mem_ready,
  output logic        PC_out,
  output logic        ZHigh_out,
  output logic        ZLow_out,
  output logic        HI_out,
  output logic        LO_out,
  output logic        MDR_out,
  output logic        C_out,
  output logic        In_port_out,
  output logic        MAR_enable,
  output logic        MDR_enable,
  output logic        Z_enable,
  output logic        Y_enable,
  output logic        IR_enable,
  output logic        PC_enable,
  output logic        CON_enable,
  output logic        HI_enable,
  output logic        LO_enable,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  opcode,
  output logic [15:0] R_out,
  output logic [15:0] R_enable,
  output logic        run
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_LD, C_LDI, C_ST, C_ALUR, C_ALUI,
    C_MD, C_BR, C_NOP, C_HALT
  } cls_t;

  state_t     state;
  cls_t       cls;
  logic [4:0] op;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rc;
  logic [4:0] alu_op;
  logic       unused_ir;

  assign op = ir[31:27];
  assign ra = ir[26:23];
  assign rb = ir[22:19];
  assign rc = ir[18:15];
  assign unused_ir = ^ir[14:0];

  function automatic logic [15:0] onehot(input logic [3:0] idx);
    onehot = 16'd1 << idx;
  endfunction

  // Instruction class decode; unlisted opcodes fall into nop
  always_comb begin
    cls = C_NOP;
    case (op)
      5'd0:  cls = C_LD;
      5'd1:  cls = C_LDI;
      5'd2:  cls = C_ST;
      5'd3, 5'd4, 5'd5, 5'd6,
      5'd7, 5'd8, 5'd9, 5'd10:
        cls = C_ALUR;
      5'd11, 5'd12, 5'd13:
        cls = C_ALUI;
`ifdef MUL_DIV_EN
      5'd14, 5'd15:
        cls = C_MD;
`else
      5'd14, 5'd15:
        cls = C_NOP;
`endif
      5'd18: cls = C_BR;
      5'd26: cls = C_HALT;
      default: cls = C_NOP;
    endcase
  end

  // ALU opcode: immediates remap onto add/and/or, address math uses add
  always_comb begin
    alu_op = 5'd3;
    case (cls)
      C_ALUR: alu_op = op;
      C_MD:   alu_op = op;
      C_ALUI: begin
        case (op)
          5'd12:   alu_op = 5'd5;
          5'd13:   alu_op = 5'd6;
          default: alu_op = 5'd3;
        endcase
      end
      default: alu_op = 5'd3;
    endcase
  end

  // State sequencing; memory states wait for mem_ready
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_RST;
    end else begin
      unique case (state)
        S_RST: state <= S_T0;
        S_T0:  state <= S_T1;
        S_T1:  state <= mem_ready ? S_T2 : S_T1;
        S_T2: begin
          case (cls)
            C_HALT:  state <= S_HALT;
            C_NOP:   state <= S_T0;
            default: state <= S_T3;
          endcase
        end
        S_T3: state <= S_T4;
        S_T4: state <= S_T5;
        S_T5: begin
          case (cls)
            C_LD, C_ST, C_MD, C_BR:
              state <= S_T6;
            default: state <= S_T0;
          endcase
        end
        S_T6: begin
          case (cls)
            C_LD:    state <= mem_ready ? S_T7 : S_T6;
            C_ST:    state <= S_T7;
            default: state <= S_T0;
          endcase
        end
        S_T7: begin
          case (cls)
            C_ST:    state <= mem_ready ? S_T0 : S_T7;
            default: state <= S_T0;
          endcase
        end
        S_HALT: state <= S_HALT;
        default: state <= S_RST;
      endcase
    end
  end

  // Moore output decode from state, IR fields and con_ff
  always_comb begin
    PC_out      = 1'b0;
    ZHigh_out   = 1'b0;
    ZLow_out    = 1'b0;
    HI_out      = 1'b0;
    LO_out      = 1'b0;
    MDR_out     = 1'b0;
    C_out       = 1'b0;
    In_port_out = 1'b0;
    MAR_enable  = 1'b0;
    MDR_enable  = 1'b0;
    Z_enable    = 1'b0;
    Y_enable    = 1'b0;
    IR_enable   = 1'b0;
    PC_enable   = 1'b0;
    CON_enable  = 1'b0;
    HI_enable   = 1'b0;
    LO_enable   = 1'b0;
    IncPC       = 1'b0;
    Read        = 1'b0;
    Write       = 1'b0;
    opcode      = 5'd0;
    R_out       = 16'd0;
    R_enable    = 16'd0;
    run         = 1'b0;
    unique case (state)
      S_RST, S_HALT: begin
        run = 1'b0;
      end
      S_T0: begin
        run        = 1'b1;
        PC_out     = 1'b1;
        MAR_enable = 1'b1;
        PC_enable  = 1'b1;
        IncPC      = 1'b1;
      end
      S_T1: begin
        run        = 1'b1;
        Read       = 1'b1;
        MDR_enable = 1'b1;
      end
      S_T2: begin
        run       = 1'b1;
        MDR_out   = 1'b1;
        IR_enable = 1'b1;
      end
      S_T3: begin
        run = 1'b1;
        case (cls)
          C_ALUR, C_ALUI, C_LDI, C_LD, C_ST: begin
            R_out    = onehot(rb);
            Y_enable = 1'b1;
          end
`ifdef MUL_DIV_EN
          C_MD: begin
            R_out    = onehot(ra);
            Y_enable = 1'b1;
          end
`endif
          C_BR: begin
            R_out      = onehot(ra);
            CON_enable = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        run = 1'b1;
        case (cls)
          C_ALUR: begin
            R_out    = onehot(rc);
            opcode   = alu_op;
            Z_enable = 1'b1;
          end
          C_ALUI, C_LDI, C_LD, C_ST: begin
            C_out    = 1'b1;
            opcode   = alu_op;
            Z_enable = 1'b1;
          end
`ifdef MUL_DIV_EN
          C_MD: begin
            R_out    = onehot(rb);
            opcode   = alu_op;
            Z_enable = 1'b1;
          end
`endif
          C_BR: begin
            PC_out   = 1'b1;
            Y_enable = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        run = 1'b1;
        case (cls)
          C_ALUR, C_ALUI, C_LDI: begin
            ZLow_out = 1'b1;
            R_enable = onehot(ra);
          end
          C_LD, C_ST: begin
            ZLow_out   = 1'b1;
            MAR_enable = 1'b1;
          end
`ifdef MUL_DIV_EN
          C_MD: begin
            ZLow_out  = 1'b1;
            LO_enable = 1'b1;
          end
`endif
          C_BR: begin
            C_out    = 1'b1;
            opcode   = 5'd3;
            Z_enable = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        run = 1'b1;
        case (cls)
          C_LD: begin
            Read       = 1'b1;
            MDR_enable = 1'b1;
          end
          C_ST: begin
            R_out      = onehot(ra);
            MDR_enable = 1'b1;
          end
`ifdef MUL_DIV_EN
          C_MD: begin
            ZHigh_out = 1'b1;
            HI_enable = 1'b1;
          end
`endif
          C_BR: begin
            ZLow_out  = 1'b1;
            PC_enable = con_ff;
          end
          default: ;
        endcase
      end
      S_T7: begin
        run = 1'b1;
        case (cls)
          C_LD: begin
            MDR_out  = 1'b1;
            R_enable = onehot(ra);
          end
          C_ST: begin
            Write = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule
